// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps all four input vectors of a 2-input gate and checks its truth table
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 9,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] exp_tt,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       pass,
    output logic [3:0] obs_tt,
    output logic [3:0] fail_mask
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("gate_sweep_ctrl: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       exp_q;
    logic [3:0]       obs_next;
    logic [3:0]       mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == '0 && vec == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Truth table including the sample taken this edge; case inequality so an unknown sample fails.
    always_comb begin
        obs_next      = obs_tt;
        obs_next[vec] = gate_y;
        for (int i = 0; i < 4; i++) begin
            mismatch[i] = (obs_next[i] !== exp_q[i]);
        end
    end

    assign busy = (state == SETTLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec       <= 2'd0;
            cnt       <= '0;
            exp_q     <= 4'd0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            valid     <= 1'b0;
            pass      <= 1'b0;
            obs_tt    <= 4'd0;
            fail_mask <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q     <= exp_tt;
                        obs_tt    <= 4'd0;
                        fail_mask <= 4'd0;
                        valid     <= 1'b0;
                        pass      <= 1'b0;
                        vec       <= 2'd0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        cnt       <= RELOAD;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        vec       <= 2'd0;
                        cnt       <= '0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        valid     <= 1'b0;
                        pass      <= 1'b0;
                        obs_tt    <= 4'd0;
                        fail_mask <= 4'd0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        obs_tt <= obs_next;
                        if (vec == 2'd3) begin
                            // Results register on the final sample so they show in the DONE cycle.
                            vec       <= 2'd0;
                            gate_a    <= 1'b0;
                            gate_b    <= 1'b0;
                            fail_mask <= mismatch;
                            pass      <= ~|mismatch;
                            valid     <= 1'b1;
                        end else begin
                            vec              <= vec + 2'd1;
                            {gate_a, gate_b} <= vec + 2'd1;
                            cnt              <= RELOAD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
